// File: rtl/dht11_scheduler_pkg.sv
// Shared DHT11 scheduler definitions: FSM encoding and default timing constants.
package dht11_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTrig = 2'd1,
    StBusy = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam int unsigned DefClkHz     = 100_000_000;
  localparam int unsigned DefPeriodMs  = 2000;
  localparam int unsigned DefTimeoutMs = 30;
  localparam int unsigned DefMaxRetry  = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dht11_scheduler_tick_gen.sv
// Free-running 1 ms strobe: one-cycle pulse every CLK_HZ/1000 clocks.
module tick_gen_1ms #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int unsigned Div  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  // Wrap the divider at Div-1; the wrap cycle is the tick.
  always_comb begin
    wrap  = (cnt_q == CntW'(Div - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ms_tick = wrap;

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 read scheduler: paces sensor triggers, retries failed reads and
// holds the last good humidity/temperature sample.
module dht11_scheduler
  import dht11_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DefClkHz,
  parameter int unsigned PERIOD_MS  = DefPeriodMs,
  parameter int unsigned TIMEOUT_MS = DefTimeoutMs,
  parameter int unsigned MAX_RETRY  = DefMaxRetry
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        req_now,
  input  logic        fresh_ack,
  output logic        dht_start,
  input  logic        dht_done,
  input  logic        dht_valid,
  input  logic [15:0] dht_humidity,
  input  logic [15:0] dht_temperature,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        data_fresh,
  output logic        err,
  output logic        busy,
  output logic [1:0]  retry_cnt
);

  localparam int unsigned MsMax = max_u(PERIOD_MS, TIMEOUT_MS);
  localparam int unsigned MsW   = $clog2(MsMax + 1) + 1;
  localparam logic [MsW-1:0] PeriodCnt  = MsW'(PERIOD_MS);
  localparam logic [MsW-1:0] TimeoutCnt = MsW'(TIMEOUT_MS);
  localparam logic [MsW-1:0] MsSat      = '1;

  logic ms_tick;

  tick_gen_1ms #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .ms_tick (ms_tick)
  );

  state_e          state_q, state_d;
  logic [MsW-1:0]  ms_cnt_q, ms_cnt_d, ms_inc;
  logic            req_pending_q, req_pending_d;
  logic            dht_start_q, dht_start_d;
  logic            busy_q, busy_d;
  logic            data_fresh_q, data_fresh_d;
  logic            err_q, err_d;
  logic [1:0]      retry_cnt_q, retry_cnt_d;
  logic [15:0]     humidity_q, humidity_d;
  logic [15:0]     temperature_q, temperature_d;
  logic            fail;

  // Next-state logic for the FSM and every registered output.
  always_comb begin
    state_d       = state_q;
    ms_cnt_d      = ms_cnt_q;
    req_pending_d = req_pending_q;
    dht_start_d   = 1'b0;
    data_fresh_d  = data_fresh_q;
    err_d         = err_q;
    retry_cnt_d   = retry_cnt_q;
    humidity_d    = humidity_q;
    temperature_d = temperature_q;
    fail          = 1'b0;

    ms_inc = (ms_cnt_q == MsSat) ? ms_cnt_q : ms_cnt_q + 1'b1;
    if ((state_q == StBusy || state_q == StHold) && ms_tick) ms_cnt_d = ms_inc;

    // Ack clears first so a same-cycle capture below overrides it.
    if (fresh_ack) data_fresh_d = 1'b0;
    if (req_now && state_q != StTrig) req_pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (enable || req_pending_q || retry_cnt_q != 2'd0) begin
          state_d     = StTrig;
          ms_cnt_d    = '0;
          dht_start_d = 1'b1;
        end
      end
      StTrig: begin
        state_d       = StBusy;
        ms_cnt_d      = '0;
        req_pending_d = 1'b0;
      end
      StBusy: begin
        // A done in the timeout cycle wins over the timeout.
        if (dht_done) begin
          if (dht_valid) begin
            humidity_d    = dht_humidity;
            temperature_d = dht_temperature;
            data_fresh_d  = 1'b1;
            err_d         = 1'b0;
            retry_cnt_d   = 2'd0;
          end else begin
            fail = 1'b1;
          end
        end else if (ms_tick && ms_inc == TimeoutCnt) begin
          fail = 1'b1;
        end
        if (fail) begin
          if (32'(retry_cnt_q) < MAX_RETRY) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
          end else begin
            err_d       = 1'b1;
            retry_cnt_d = 2'd0;
          end
        end
        if (dht_done || fail) begin
          state_d  = StHold;
          ms_cnt_d = '0;
        end
      end
      StHold: begin
        if (ms_tick && ms_inc == PeriodCnt) begin
          state_d  = StIdle;
          ms_cnt_d = '0;
        end
      end
      default: state_d = StHold;
    endcase

    busy_d = (state_d == StTrig) || (state_d == StBusy);
  end

  // State and output registers; reset parks in HOLD so the sensor settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHold;
      ms_cnt_q      <= '0;
      req_pending_q <= 1'b0;
      dht_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      data_fresh_q  <= 1'b0;
      err_q         <= 1'b0;
      retry_cnt_q   <= 2'd0;
      humidity_q    <= 16'd0;
      temperature_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ms_cnt_q      <= ms_cnt_d;
      req_pending_q <= req_pending_d;
      dht_start_q   <= dht_start_d;
      busy_q        <= busy_d;
      data_fresh_q  <= data_fresh_d;
      err_q         <= err_d;
      retry_cnt_q   <= retry_cnt_d;
      humidity_q    <= humidity_d;
      temperature_q <= temperature_d;
    end
  end

  assign dht_start   = dht_start_q;
  assign busy        = busy_q;
  assign data_fresh  = data_fresh_q;
  assign err         = err_q;
  assign retry_cnt   = retry_cnt_q;
  assign humidity    = humidity_q;
  assign temperature = temperature_q;

endmodule

// File: doc/dht11_scheduler.md
DHT11_SCHEDULER -- requirements
Module: dht11_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset (clk, rst_n); the reset polarity and synchronicity are fixed.
REQ-002 Parameter CLK_HZ, default 100_000_000: clk frequency in Hz.
REQ-003 Parameter PERIOD_MS, default 2000: minimum ms from one transaction end (or reset) to the next trigger.
REQ-004 Parameter TIMEOUT_MS, default 30: ms allowed from trigger to dht_done.
REQ-005 Parameter MAX_RETRY, default 3: retries after a failed read before err is raised.
REQ-006 Ports SHALL be exactly:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- enable  in  1  periodic sampling enable
- req_now  in  1  one-cycle manual read request
- fresh_ack  in  1  one-cycle consumer acknowledge of data_fresh
- dht_start  out  1  one-cycle trigger to the sensor controller
- dht_done  in  1  one-cycle transaction-complete from the sensor controller
- dht_valid  in  1  checksum-ok, sampled with dht_done
- dht_humidity  in  16  raw humidity, sampled with dht_done
- dht_temperature  in  16  raw temperature, sampled with dht_done
- humidity  out  16  last good humidity
- temperature  out  16  last good temperature
- data_fresh  out  1  new good sample not yet acknowledged
- err  out  1  retries exhausted; sticky until the next good read
- busy  out  1  state is TRIG or BUSY
- retry_cnt  out  2  current retry number

Function
REQ-007 An internal ms_tick SHALL pulse for one cycle every CLK_HZ/1000 clk cycles, free-running from reset.
REQ-008 FSM states SHALL be IDLE, TRIG, BUSY and HOLD; a single ms counter, cleared on every state entry, SHALL count ms_tick in BUSY and HOLD and saturate at its maximum.
REQ-009 HOLD SHALL go to IDLE on the ms_tick that brings the counter to PERIOD_MS.
REQ-010 IDLE SHALL go to TRIG when enable=1, req_pending=1 or retry_cnt!=0; otherwise it SHALL stay in IDLE.
REQ-011 TRIG SHALL assert dht_start for exactly one cycle, clear req_pending, and go to BUSY on the next cycle.
REQ-012 In BUSY, dht_done=1 with dht_valid=1 SHALL, on the next clock edge: capture dht_humidity and dht_temperature into humidity and temperature; set data_fresh=1; clear err and retry_cnt; go to HOLD.
REQ-013 In BUSY, a failure (dht_done=1 with dht_valid=0, or the counter reaching TIMEOUT_MS with no done) SHALL increment retry_cnt if retry_cnt<MAX_RETRY; otherwise it SHALL set err=1 and clear retry_cnt. Either way the FSM SHALL go to HOLD.
REQ-014 If dht_done and the timeout occur in the same cycle, dht_done SHALL take priority.
REQ-015 dht_done in IDLE, TRIG or HOLD SHALL be ignored, including a late done after a timeout.
REQ-016 A req_now pulse in any state other than TRIG SHALL set req_pending; multiple pulses SHALL collapse into one read.
REQ-017 fresh_ack SHALL clear data_fresh; a simultaneous capture SHALL win, leaving data_fresh=1.
REQ-018 Deasserting enable SHALL NOT abort an in-flight transaction or its pending retries.
REQ-019 humidity and temperature SHALL change only on a good capture; no output other than dht_start SHALL pulse.

Reset
REQ-020 While rst_n=0: dht_start, data_fresh, err, busy = 0; humidity, temperature, retry_cnt = 0; req_pending = 0; FSM = HOLD with counter 0.
REQ-021 Because of REQ-020, the first trigger SHALL occur no earlier than PERIOD_MS after reset release (sensor power-up settling).
REQ-022 Reset asserted mid-transaction SHALL take effect immediately, with no dht_start issued during or on release of reset.

Structure
REQ-023 The FSM state encoding and default timing constants SHALL live in the shared DHT11 package.
REQ-024 The ms_tick generator SHALL be one sub-module, tick_gen_1ms, parameterised by CLK_HZ.

Verification (CLK_HZ=100_000, PERIOD_MS=5, TIMEOUT_MS=3, MAX_RETRY=2)
REQ-025 Release reset with enable=1 -> first dht_start 5 ms after release (±1 ms_tick), exactly one cycle wide.
REQ-026 dht_done+valid with humidity 0x2800 and temperature 0x1900 -> outputs 0x2800/0x1900 next cycle, data_fresh=1, err=0; next dht_start 5 ms later; fresh_ack clears data_fresh.
REQ-027 Three consecutive done with valid=0 -> retry_cnt 1, then 2, then err=1 with retry_cnt=0; a following good read clears err.
REQ-028 No dht_done -> BUSY exits after 3 ms and retry_cnt=1; a done pulse injected during HOLD is ignored and outputs are unchanged.
REQ-029 enable=0 and two req_now pulses during HOLD -> exactly one dht_start after HOLD expires, then no further triggers.
REQ-030 rst_n low mid-BUSY -> all outputs 0 immediately and busy=0; no dht_start until 5 ms after release.
